// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  // Sequencer states; IDLE is also the ack cycle between transactions.
  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_SETUP,
    RD_WAIT,
    RD_DRIVE
  } state_t;

  // Polarity of the memory read_write pin.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Width of the read wait-state counter (supports 0..7 wait states).
  localparam int WAIT_W = 3;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a lone eligible port wins outright, and a tie
// goes to the port that did not win last time.
module mem_arb_rr (
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_port
);

  // Pure combinational pick; the caller latches the result.
  always_comb begin
    grant_valid = |eligible;
    grant_port  = 1'b0;
    case (eligible)
      2'b01:   grant_port = 1'b0;
      2'b10:   grant_port = 1'b1;
      2'b11:   grant_port = ~last_grant;
      default: grant_port = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two single-word requesters onto one single-port memory and
// sequences the memory pins (enable, read_write, output_en, address, data).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_write,
  output logic              mem_enable,
  output logic              mem_output_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Value loaded into the wait counter on leaving RD_SETUP; unused when
  // there are no wait states, so it is clamped to zero in that case.
  localparam logic [WAIT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? WAIT_W'(WAIT_STATES - 1) : '0;

  state_t            state_reg;
  logic              last_grant_reg;
  logic              port_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;

  logic [1:0]        eligible;
  logic              grant_valid;
  logic              grant_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // A port sitting in its ack cycle is masked so a held req cannot win twice.
  assign eligible = {p1_req & ~p1_ack, p0_req & ~p0_ack};

  mem_arb_rr u_rr (
    .eligible   (eligible),
    .last_grant (last_grant_reg),
    .grant_valid(grant_valid),
    .grant_port (grant_port)
  );

  // Mux the winning port's request fields for capture in IDLE.
  always_comb begin
    sel_we    = p0_we;
    sel_addr  = p0_addr;
    sel_wdata = p0_wdata;
    if (grant_port) begin
      sel_we    = p1_we;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end
  end

  // Sequencer: every output is registered and set on the edge that enters
  // the state it belongs to, so pins line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      port_reg       <= 1'b0;
      wait_cnt_reg   <= '0;
      mem_address    <= '0;
      mem_read_write <= RW_READ;
      mem_enable     <= 1'b0;
      mem_output_en  <= 1'b0;
      mem_wdata      <= '0;
      p0_ack         <= 1'b0;
      p1_ack         <= 1'b0;
      p0_rdata       <= '0;
      p1_rdata       <= '0;
      busy           <= 1'b0;
    end else begin
      // Acks are single-cycle pulses; only the completing states raise one.
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            last_grant_reg <= grant_port;
            port_reg       <= grant_port;
            mem_address    <= sel_addr;
            mem_enable     <= 1'b1;
            mem_output_en  <= 1'b0;
            busy           <= 1'b1;
            if (sel_we) begin
              mem_read_write <= RW_WRITE;
              mem_wdata      <= sel_wdata;
              state_reg      <= WRITE;
            end else begin
              mem_read_write <= RW_READ;
              state_reg      <= RD_SETUP;
            end
          end
        end
        WRITE: begin
          state_reg      <= IDLE;
          mem_enable     <= 1'b0;
          mem_read_write <= RW_READ;
          mem_output_en  <= 1'b0;
          busy           <= 1'b0;
          if (port_reg) p1_ack <= 1'b1;
          else          p0_ack <= 1'b1;
        end
        RD_SETUP: begin
          if (WAIT_STATES == 0) begin
            state_reg     <= RD_DRIVE;
            mem_output_en <= 1'b1;
          end else begin
            wait_cnt_reg <= WAIT_LOAD;
            state_reg    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (wait_cnt_reg == '0) begin
            state_reg     <= RD_DRIVE;
            mem_output_en <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
          end
        end
        RD_DRIVE: begin
          state_reg      <= IDLE;
          mem_enable     <= 1'b0;
          mem_read_write <= RW_READ;
          mem_output_en  <= 1'b0;
          busy           <= 1'b0;
          if (port_reg) begin
            p1_rdata <= mem_rdata;
            p1_ack   <= 1'b1;
          end else begin
            p0_rdata <= mem_rdata;
            p0_ack   <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (0 and 3 wait states), each with a
// behavioural memory macro, a transaction-timeline reference model and a
// per-cycle compare, plus directed scenarios with literal expectations.
module tb_mem_arbiter;

  localparam int WS1 = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load_mem = 1'b1;

  always #5 clk = ~clk;

  logic        req   [2][2];
  logic        we    [2][2];
  logic [15:0] addr  [2][2];
  logic [15:0] wdata [2][2];
  logic        ack   [2][2];
  logic [15:0] rdata [2][2];

  logic [15:0] d_addr [2];
  logic        d_rw   [2];
  logic        d_en   [2];
  logic        d_oe   [2];
  logic [15:0] d_wd   [2];
  logic [15:0] d_rd   [2];
  logic        d_busy [2];

  int checks = 0;
  int errors = 0;
  int order_q[$];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [15:0] mem_q [256];

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(gi == 0 ? 0 : WS1)) dut (
      .clk           (clk),
      .reset         (reset),
      .p0_req        (req[gi][0]),
      .p0_we         (we[gi][0]),
      .p0_addr       (addr[gi][0]),
      .p0_wdata      (wdata[gi][0]),
      .p0_ack        (ack[gi][0]),
      .p0_rdata      (rdata[gi][0]),
      .p1_req        (req[gi][1]),
      .p1_we         (we[gi][1]),
      .p1_addr       (addr[gi][1]),
      .p1_wdata      (wdata[gi][1]),
      .p1_ack        (ack[gi][1]),
      .p1_rdata      (rdata[gi][1]),
      .mem_address   (d_addr[gi]),
      .mem_read_write(d_rw[gi]),
      .mem_enable    (d_en[gi]),
      .mem_output_en (d_oe[gi]),
      .mem_wdata     (d_wd[gi]),
      .mem_rdata     (d_rd[gi]),
      .busy          (d_busy[gi])
    );

    // Memory macro: drives data only while enabled with output drive on.
    assign d_rd[gi] = (d_en[gi] && d_oe[gi]) ? mem_q[d_addr[gi][7:0]] : 16'hDEAD;

    always @(posedge clk) begin
      if (load_mem) begin
        for (int j = 0; j < 256; j++) mem_q[j] <= 16'h1000 + 16'(j);
      end else if (d_en[gi] && !d_rw[gi]) begin
        mem_q[d_addr[gi][7:0]] <= d_wd[gi];
      end
    end
  end

  // ---------------- reference model (transaction timeline) ----------------
  // A granted transaction occupies cycles 1..len after the grant cycle
  // (len = 1 for a write, 2 + wait states for a read), output drive only in
  // its last cycle, and the ack lands in the cycle after that.
  bit          md_act  [2];
  int          md_port [2];
  bit          md_we   [2];
  logic [15:0] md_addr [2];
  logic [15:0] md_wd   [2];
  int          md_k    [2];
  int          md_len  [2];
  int          md_last [2];
  logic [15:0] e_addr  [2];
  logic [15:0] e_wd    [2];
  bit          e_ack   [2][2];
  logic [15:0] e_rd    [2][2];
  bit          req_q   [2][2];
  logic [15:0] shadow  [2][256];

  task automatic model_step();
    bit el0, el1;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        md_act[i] = 0; md_last[i] = 1; md_k[i] = 0; md_len[i] = 0;
        md_port[i] = 0; md_we[i] = 0; md_addr[i] = '0; md_wd[i] = '0;
        e_addr[i] = '0; e_wd[i] = '0;
        for (int p = 0; p < 2; p++) begin
          e_ack[i][p] = 0; e_rd[i][p] = '0; req_q[i][p] = 0;
        end
        if (load_mem) for (int j = 0; j < 256; j++) shadow[i][j] = 16'h1000 + 16'(j);
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        for (int p = 0; p < 2; p++) begin
          if (req_q[i][p] && !req[i][p] && !e_ack[i][p]) begin
            errors++;
            $display("FAIL protocol inst%0d port%0d: req dropped before ack", i, p);
          end
          req_q[i][p] = req[i][p];
        end
        if (!md_act[i]) begin
          el0 = req[i][0] && !e_ack[i][0];
          el1 = req[i][1] && !e_ack[i][1];
          e_ack[i][0] = 0; e_ack[i][1] = 0;
          if (el0 || el1) begin
            md_port[i] = (el0 && el1) ? ((md_last[i] == 0) ? 1 : 0) : (el1 ? 1 : 0);
            md_last[i] = md_port[i];
            md_act[i]  = 1;
            md_k[i]    = 1;
            md_we[i]   = we[i][md_port[i]];
            md_addr[i] = addr[i][md_port[i]];
            md_wd[i]   = wdata[i][md_port[i]];
            md_len[i]  = md_we[i] ? 1 : 2 + ((i == 0) ? 0 : WS1);
          end
        end else begin
          e_ack[i][0] = 0; e_ack[i][1] = 0;
          md_k[i]++;
          if (md_k[i] > md_len[i]) begin
            md_act[i] = 0;
            e_ack[i][md_port[i]] = 1;
            if (md_we[i]) shadow[i][md_addr[i][7:0]] = md_wd[i];
            else          e_rd[i][md_port[i]] = shadow[i][md_addr[i][7:0]];
          end
        end
        if (md_act[i]) begin
          e_addr[i] = md_addr[i];
          if (md_we[i]) e_wd[i] = md_wd[i];
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h", name, i, act, exp);
    end
  endtask

  // Per-cycle compare of every meaningful output against the model.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("mem_enable", i, 32'(d_en[i]), 32'(md_act[i]));
      chk("mem_read_write", i, 32'(d_rw[i]), 32'(!(md_act[i] && md_we[i])));
      chk("mem_output_en", i, 32'(d_oe[i]),
          32'(md_act[i] && !md_we[i] && md_k[i] == md_len[i]));
      chk("busy", i, 32'(d_busy[i]), 32'(md_act[i]));
      chk("mem_address", i, 32'(d_addr[i]), 32'(e_addr[i]));
      if (md_act[i] && md_we[i]) chk("mem_wdata", i, 32'(d_wd[i]), 32'(e_wd[i]));
      for (int p = 0; p < 2; p++) begin
        chk(p == 0 ? "p0_ack" : "p1_ack", i, 32'(ack[i][p]), 32'(e_ack[i][p]));
        if (e_ack[i][p]) chk(p == 0 ? "p0_rdata" : "p1_rdata", i, 32'(rdata[i][p]), 32'(e_rd[i][p]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(int i, int p, bit w, logic [15:0] a, logic [15:0] d);
    we[i][p] = w; addr[i][p] = a; wdata[i][p] = d; req[i][p] = 1'b1;
  endtask

  task automatic wait_ack(int i, int p, output int cyc, output logic [15:0] rd);
    cyc = 0;
    rd = '0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ack[i][p] === 1'b1) break;
    end
    if (ack[i][p] !== 1'b1) begin
      errors++;
      $display("FAIL ack_timeout inst%0d port%0d: no ack within 40 cycles", i, p);
    end else begin
      rd = rdata[i][p];
      order_q.push_back(p);
    end
    $display("txn inst%0d port%0d done after %0d cycles rdata=%h", i, p, cyc, rd);
  endtask

  initial begin
    int c, lo, hi;
    logic [15:0] rd;
    int exp_alt[4];
    int exp_hold[3];
    exp_alt  = '{0, 1, 0, 1};
    exp_hold = '{0, 1, 0};
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        req[i][p] = 0; we[i][p] = 0; addr[i][p] = '0; wdata[i][p] = '0;
      end
    repeat (2) @(negedge clk);
    load_mem = 0;
    for (int i = 0; i < 2; i++) begin
      chk("reset_enable", i, 32'(d_en[i]), 0);
      chk("reset_rw", i, 32'(d_rw[i]), 1);
      chk("reset_busy", i, 32'(d_busy[i]), 0);
      chk("reset_address", i, 32'(d_addr[i]), 0);
    end
    reset = 0;
    @(negedge clk);

    // Port 0 write 5A5A to 0000, port 1 idle.
    set_req(0, 0, 1, 16'h0000, 16'h5A5A);
    @(negedge clk);
    chk("wr_enable_n1", 0, 32'(d_en[0]), 1);
    chk("wr_rw_n1", 0, 32'(d_rw[0]), 0);
    chk("wr_wdata_n1", 0, 32'(d_wd[0]), 32'h5A5A);
    @(negedge clk);
    chk("wr_ack_n2", 0, 32'(ack[0][0]), 1);
    chk("wr_p1_ack_n2", 0, 32'(ack[0][1]), 0);
    $display("txn inst0 port0 write 0000=5A5A");
    req[0][0] = 0;
    repeat (2) @(negedge clk);

    // Port 1 write A5A5 to 0010, then read it back with no wait states.
    set_req(0, 1, 1, 16'h0010, 16'hA5A5);
    wait_ack(0, 1, c, rd);
    chk("p1_write_latency", 0, 32'(c), 2);
    req[0][1] = 0;
    @(negedge clk);
    set_req(0, 1, 0, 16'h0010, 16'h0000);
    @(negedge clk);
    chk("rd_setup_oe", 0, 32'(d_oe[0]), 0);
    chk("rd_setup_en", 0, 32'(d_en[0]), 1);
    @(negedge clk);
    chk("rd_drive_oe", 0, 32'(d_oe[0]), 1);
    @(negedge clk);
    chk("rd_ack_n3", 0, 32'(ack[0][1]), 1);
    chk("rd_rdata_n3", 0, 32'(rdata[0][1]), 32'hA5A5);
    $display("txn inst0 port1 read 0010=%h", rdata[0][1]);
    req[0][1] = 0;
    @(negedge clk);

    // From reset, both ports read and keep requesting: grants alternate.
    reset = 1;
    @(negedge clk);
    reset = 0;
    order_q.delete();
    fork
      begin
        for (int n = 0; n < 2; n++) begin
          logic [15:0] r0;
          int c0;
          set_req(0, 0, 0, 16'h0000, 16'h0000);
          wait_ack(0, 0, c0, r0);
          chk("both_p0_rdata", 0, 32'(r0), 32'h5A5A);
        end
        req[0][0] = 0;
      end
      begin
        for (int n = 0; n < 2; n++) begin
          logic [15:0] r1;
          int c1;
          set_req(0, 1, 0, 16'h0010, 16'h0000);
          wait_ack(0, 1, c1, r1);
          chk("both_p1_rdata", 0, 32'(r1), 32'hA5A5);
        end
        req[0][1] = 0;
      end
    join
    chk("alt_count", 0, 32'(order_q.size()), 4);
    for (int k = 0; k < 4 && k < order_q.size(); k++)
      chk("alt_order", 0, 32'(order_q[k]), 32'(exp_alt[k]));
    @(negedge clk);

    // Three wait states: write then read 0000 on instance 1.
    set_req(1, 0, 1, 16'h0000, 16'h5A5A);
    wait_ack(1, 0, c, rd);
    chk("ws3_write_latency", 1, 32'(c), 2);
    req[1][0] = 0;
    @(negedge clk);
    set_req(1, 0, 0, 16'h0000, 16'h0000);
    lo = 0; hi = 0; c = 0;
    do begin
      @(negedge clk);
      c++;
      if (d_en[1] && !d_oe[1]) lo++;
      if (d_en[1] && d_oe[1]) hi++;
    end while (ack[1][0] !== 1'b1 && c < 40);
    chk("ws3_read_latency", 1, 32'(c), 6);
    chk("ws3_oe_low_cycles", 1, 32'(lo), 4);
    chk("ws3_oe_high_cycles", 1, 32'(hi), 1);
    chk("ws3_rdata", 1, 32'(rdata[1][0]), 32'h5A5A);
    $display("txn inst1 port0 read 0000=%h after %0d cycles", rdata[1][0], c);
    req[1][0] = 0;
    @(negedge clk);

    // Reset during RD_WAIT aborts the read; the held req completes after.
    set_req(1, 1, 0, 16'h0010, 16'h0000);
    repeat (3) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("abort_enable", 1, 32'(d_en[1]), 0);
    chk("abort_oe", 1, 32'(d_oe[1]), 0);
    chk("abort_rw", 1, 32'(d_rw[1]), 1);
    chk("abort_address", 1, 32'(d_addr[1]), 0);
    chk("abort_busy", 1, 32'(d_busy[1]), 0);
    chk("abort_ack", 1, 32'(ack[1][1]), 0);
    @(negedge clk);
    reset = 0;
    wait_ack(1, 1, c, rd);
    chk("after_reset_latency", 1, 32'(c), 6);
    chk("after_reset_rdata", 1, 32'(rd), 32'h1010);
    req[1][1] = 0;
    @(negedge clk);

    // Port 0 holds req through its ack while port 1 waits: port 1 goes next.
    order_q.delete();
    fork
      begin
        logic [15:0] ra;
        int ca;
        set_req(0, 0, 1, 16'h0020, 16'h1111);
        wait_ack(0, 0, ca, ra);
        set_req(0, 0, 1, 16'h0021, 16'h2222);
        wait_ack(0, 0, ca, ra);
        req[0][0] = 0;
      end
      begin
        logic [15:0] rb;
        int cb;
        @(negedge clk);
        set_req(0, 1, 0, 16'h0010, 16'h0000);
        wait_ack(0, 1, cb, rb);
        chk("hold_p1_rdata", 0, 32'(rb), 32'hA5A5);
        req[0][1] = 0;
      end
    join
    chk("hold_count", 0, 32'(order_q.size()), 3);
    for (int k = 0; k < 3 && k < order_q.size(); k++)
      chk("hold_order", 0, 32'(order_q[k]), 32'(exp_hold[k]));

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
